// File: rtl/rx_unstuff_shift_pkg.sv
// -----------------------------------------------------------------------------
// rx_unstuff_shift_pkg
// Shared constants and types for the USB receive bit-unstuffing path.
//   STUFF_LEN  : run of consecutive 1s after which a stuffed 0 must follow
//   BYTE_W     : width of each assembled output byte
//   CNT_W      : width of the ones-run counter (must hold 0..STUFF_LEN)
//   IDX_W      : width of the bit position counter inside a byte
//   state_t    : receive FSM states
// -----------------------------------------------------------------------------
package rx_unstuff_shift_pkg;

    localparam int STUFF_LEN = 6;
    localparam int BYTE_W    = 8;
    localparam int CNT_W     = $clog2(STUFF_LEN + 1);
    localparam int IDX_W     = $clog2(BYTE_W);

    // Counter value that marks the stuff position, and the value just before it
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STUFF_LEN);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(STUFF_LEN - 1);

    // Bit index of the final bit of a byte
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTE_W - 1);

    // IDLE  : nothing received since reset/clear/eop
    // SHIFT : accepting data bits
    // STUFF : a full run of 1s was seen, the next strobe is the stuff position
    // ERR   : a stuffing violation happened, data is still assembled
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STUFF = 2'd2,
        ERR   = 2'd3
    } state_t;

endpackage

// File: rtl/rx_unstuff_shift_if.sv
// -----------------------------------------------------------------------------
// rx_unstuff_shift_if
// Bundles the bit-stream inputs and the byte/flag outputs of the unstuffer.
//   d_orig        : decoded bit from the NRZI decoder
//   shift_enable  : one-cycle strobe, d_orig carries a new bit
//   clear         : start-of-packet clear of all state including errors
//   eop           : end-of-packet, flushes bit state, keeps errors
//   rx_byte       : last completed byte, held until the next byte_ready
//   byte_ready    : one-cycle pulse, rx_byte newly valid
//   stuff_bit     : one-cycle pulse, the last strobed bit was a stuffed 0
//   stuff_err     : sticky stuffing violation flag
//   align_err     : one-cycle pulse, packet ended with a partial byte
// master = decoder side driving the stream, slave = the unstuffer.
// -----------------------------------------------------------------------------
interface rx_unstuff_shift_if;
    import rx_unstuff_shift_pkg::*;

    logic              d_orig;
    logic              shift_enable;
    logic              clear;
    logic              eop;
    logic [BYTE_W-1:0] rx_byte;
    logic              byte_ready;
    logic              stuff_bit;
    logic              stuff_err;
    logic              align_err;

    modport master (
        output d_orig, shift_enable, clear, eop,
        input  rx_byte, byte_ready, stuff_bit, stuff_err, align_err
    );

    modport slave (
        input  d_orig, shift_enable, clear, eop,
        output rx_byte, byte_ready, stuff_bit, stuff_err, align_err
    );

endinterface

// File: rtl/rx_unstuff_shift_stuff_counter.sv
// -----------------------------------------------------------------------------
// stuff_counter
// Counts consecutive 1s on accepted data bits, saturating at LIMIT.
//   clk, rst   : clock and async active-high reset
//   i_clear    : synchronous clear to zero (wins over counting)
//   i_enable   : an accepted data bit is present this cycle
//   i_bit      : the data bit value
//   o_count    : current run length of 1s
//   o_terminal : run length has reached LIMIT
// -----------------------------------------------------------------------------
module stuff_counter
    import rx_unstuff_shift_pkg::*;
#(
    parameter int             W     = CNT_W,
    parameter logic [W-1:0]   LIMIT = CNT_LIMIT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_enable,
    input  logic         i_bit,
    output logic [W-1:0] o_count,
    output logic         o_terminal
);

    logic [W-1:0] r_count;

    // A 0 restarts the run; a 1 extends it but never beyond LIMIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (!i_bit) begin
                r_count <= '0;
            end else if (r_count != LIMIT) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == LIMIT);

endmodule

// File: rtl/rx_unstuff_shift.sv
// -----------------------------------------------------------------------------
// rx_unstuff_shift
// Removes USB stuff bits from the decoded receive stream and assembles the
// remaining data bits LSB-first into bytes.
//   clk  : system clock
//   rst  : async active-high reset
//   bus  : slave side of rx_unstuff_shift_if (bit stream in, bytes/flags out)
// All outputs are registered; byte_ready/stuff_bit/align_err appear the cycle
// after the strobe (or eop) that caused them.
// -----------------------------------------------------------------------------
module rx_unstuff_shift
    import rx_unstuff_shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    rx_unstuff_shift_if.slave bus
);

    state_t            r_state;
    state_t            w_nextState;

    logic [BYTE_W-1:0] r_shreg;
    logic [BYTE_W-1:0] r_rxByte;
    logic [BYTE_W-1:0] w_shifted;
    logic [IDX_W-1:0]  r_bitIdx;

    logic              r_byteReady;
    logic              r_stuffBit;
    logic              r_stuffErr;
    logic              r_alignErr;

    logic [CNT_W-1:0]  w_onesCnt;
    logic              w_terminal;
    logic              w_flush;
    logic              w_dataBit;
    logic              w_stuffOk;
    logic              w_stuffViol;
    logic              w_cntClear;

    // clear and eop both end the current packet; any strobe with them is ignored
    assign w_flush   = bus.clear | bus.eop;
    assign w_shifted = {bus.d_orig, r_shreg[BYTE_W-1:1]};

    // The ones run restarts on packet boundaries and on every stuff position
    assign w_cntClear = w_flush | w_stuffOk | w_stuffViol;

    stuff_counter #(
        .W     (CNT_W),
        .LIMIT (CNT_LIMIT)
    ) u_stuff_counter (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_cntClear),
        .i_enable   (w_dataBit),
        .i_bit      (bus.d_orig),
        .o_count    (w_onesCnt),
        .o_terminal (w_terminal)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and per-strobe classification. The transition into STUFF is
    // decided on the strobe that completes the run, so the following strobe is
    // already known to be the stuff position. The counter's terminal flag is
    // also required there so a state/counter disagreement never discards data.
    always_comb begin
        w_nextState = r_state;
        w_dataBit   = 1'b0;
        w_stuffOk   = 1'b0;
        w_stuffViol = 1'b0;

        if (w_flush) begin
            w_nextState = IDLE;
        end else if (bus.shift_enable) begin
            case (r_state)
                IDLE, SHIFT, ERR: begin
                    w_dataBit = 1'b1;
                    if (bus.d_orig && (w_onesCnt == CNT_PRE)) begin
                        w_nextState = STUFF;
                    end else if (r_state == IDLE) begin
                        w_nextState = SHIFT;
                    end
                end
                STUFF: begin
                    if (!w_terminal) begin
                        w_dataBit   = 1'b1;
                        w_nextState = SHIFT;
                    end else if (bus.d_orig) begin
                        w_stuffViol = 1'b1;
                        w_nextState = ERR;
                    end else begin
                        w_stuffOk   = 1'b1;
                        w_nextState = SHIFT;
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // Shift register, byte assembly and flag registers. Pulses default low
    // each cycle. eop reports a partial byte; clear additionally drops the
    // sticky error and never reports alignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg     <= '0;
            r_rxByte    <= '0;
            r_bitIdx    <= '0;
            r_byteReady <= 1'b0;
            r_stuffBit  <= 1'b0;
            r_stuffErr  <= 1'b0;
            r_alignErr  <= 1'b0;
        end else begin
            r_byteReady <= 1'b0;
            r_stuffBit  <= 1'b0;
            r_alignErr  <= 1'b0;

            if (bus.clear) begin
                r_shreg    <= '0;
                r_bitIdx   <= '0;
                r_stuffErr <= 1'b0;
            end else if (bus.eop) begin
                r_shreg    <= '0;
                r_bitIdx   <= '0;
                r_alignErr <= (r_bitIdx != '0);
            end else begin
                if (w_dataBit) begin
                    r_shreg <= w_shifted;
                    if (r_bitIdx == LAST_IDX) begin
                        r_bitIdx    <= '0;
                        r_rxByte    <= w_shifted;
                        r_byteReady <= 1'b1;
                    end else begin
                        r_bitIdx <= r_bitIdx + 1'b1;
                    end
                end
                if (w_stuffOk) begin
                    r_stuffBit <= 1'b1;
                end
                if (w_stuffViol) begin
                    r_stuffErr <= 1'b1;
                end
            end
        end
    end

    assign bus.rx_byte    = r_rxByte;
    assign bus.byte_ready = r_byteReady;
    assign bus.stuff_bit  = r_stuffBit;
    assign bus.stuff_err  = r_stuffErr;
    assign bus.align_err  = r_alignErr;

endmodule

// File: tb/tb_rx_unstuff_shift.sv
// -----------------------------------------------------------------------------
// tb_rx_unstuff_shift
// Directed bench for rx_unstuff_shift with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled 1ns after the
// rising edge on which they update.
// -----------------------------------------------------------------------------
module tb_rx_unstuff_shift;

    logic clk;
    logic rst;

    rx_unstuff_shift_if bus ();

    rx_unstuff_shift dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nChecks = 0;
    int nBad    = 0;

    // Pulse monitor: records every byte and stuff pulse seen mid-cycle
    logic [7:0] seenBytes[$];
    int         stuffPulses = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Collect pulse outputs at the falling edge, well away from updates
    always @(negedge clk) begin
        if (bus.byte_ready) begin
            seenBytes.push_back(bus.rx_byte);
        end
        if (bus.stuff_bit) begin
            stuffPulses++;
        end
    end

    // Single comparison point; every check goes through here
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nBad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One data strobe carrying bit b
    task automatic applyStimulus(input logic b);
        @(negedge clk);
        bus.shift_enable = 1'b1;
        bus.d_orig       = b;
        @(posedge clk);
        #1;
        bus.shift_enable = 1'b0;
        bus.d_orig       = 1'b0;
    endtask

    // First n bits of v, LSB first
    task automatic sendBits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(v[i]);
        end
    endtask

    task automatic pulseClear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
    endtask

    task automatic pulseEop(input logic withStrobe);
        @(negedge clk);
        bus.eop          = 1'b1;
        bus.shift_enable = withStrobe;
        bus.d_orig       = withStrobe;
        @(posedge clk);
        #1;
        bus.eop          = 1'b0;
        bus.shift_enable = 1'b0;
        bus.d_orig       = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " rx_byte"},    32'(bus.rx_byte),    32'h00);
        checkOutput({tag, " byte_ready"}, 32'(bus.byte_ready), 32'h0);
        checkOutput({tag, " stuff_bit"},  32'(bus.stuff_bit),  32'h0);
        checkOutput({tag, " stuff_err"},  32'(bus.stuff_err),  32'h0);
        checkOutput({tag, " align_err"},  32'(bus.align_err),  32'h0);
    endtask

    initial begin
        int stuffBase;
        int byteBase;

        rst              = 1'b1;
        bus.d_orig       = 1'b0;
        bus.shift_enable = 1'b0;
        bus.clear        = 1'b0;
        bus.eop          = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: byte 0xA5, LSB first
        pulseClear();
        sendBits(8'hA5, 7);
        checkOutput("t1 no ready after 7 bits", 32'(bus.byte_ready), 32'h0);
        applyStimulus(1'b1);
        checkOutput("t1 byte_ready", 32'(bus.byte_ready), 32'h1);
        checkOutput("t1 rx_byte",    32'(bus.rx_byte),    32'hA5);
        checkOutput("t1 stuff_bit",  32'(bus.stuff_bit),  32'h0);
        idleCycle();
        checkOutput("t1 ready is a pulse", 32'(bus.byte_ready), 32'h0);

        // 2: 0x3F with stuffed 0 after six 1s, then 0x01
        pulseClear();
        stuffBase = stuffPulses;
        byteBase  = seenBytes.size();
        sendBits(8'hFF, 6);
        applyStimulus(1'b0);
        checkOutput("t2 stuff_bit pulse", 32'(bus.stuff_bit), 32'h1);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        sendBits(8'h01, 8);
        idleCycle();
        checkOutput("t2 stuff pulse count", 32'(stuffPulses - stuffBase), 32'd1);
        checkOutput("t2 byte count", 32'(seenBytes.size() - byteBase), 32'd2);
        if (seenBytes.size() - byteBase >= 2) begin
            checkOutput("t2 first byte",  32'(seenBytes[byteBase]),     32'h3F);
            checkOutput("t2 second byte", 32'(seenBytes[byteBase + 1]), 32'h01);
        end
        checkOutput("t2 stuff_err", 32'(bus.stuff_err), 32'h0);

        // 3: violation at the stuff position, sticky through eop
        pulseClear();
        sendBits(8'hFF, 6);
        applyStimulus(1'b1);
        checkOutput("t3 stuff_err set", 32'(bus.stuff_err), 32'h1);
        sendBits(8'h00, 3);
        pulseEop(1'b0);
        idleCycle();
        checkOutput("t3 stuff_err after eop", 32'(bus.stuff_err), 32'h1);
        pulseClear();
        checkOutput("t3 stuff_err after clear", 32'(bus.stuff_err), 32'h0);

        // 4: 0xFF as 111111 0(stuff) 11
        pulseClear();
        stuffBase = stuffPulses;
        sendBits(8'hFF, 6);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("t4 no ready on 8th strobe", 32'(bus.byte_ready), 32'h0);
        applyStimulus(1'b1);
        checkOutput("t4 byte_ready", 32'(bus.byte_ready), 32'h1);
        checkOutput("t4 rx_byte",    32'(bus.rx_byte),    32'hFF);
        checkOutput("t4 stuff pulses", 32'(stuffPulses - stuffBase), 32'd1);

        // 5: partial byte at eop, then whole byte at eop
        pulseClear();
        sendBits(8'h1A, 5);
        pulseEop(1'b0);
        checkOutput("t5 align_err on partial", 32'(bus.align_err),  32'h1);
        checkOutput("t5 no byte on partial",   32'(bus.byte_ready), 32'h0);
        idleCycle();
        checkOutput("t5 align_err is a pulse", 32'(bus.align_err),  32'h0);
        sendBits(8'h5A, 8);
        checkOutput("t5 full byte ready", 32'(bus.byte_ready), 32'h1);
        pulseEop(1'b0);
        checkOutput("t5 no align_err on full byte", 32'(bus.align_err), 32'h0);
        checkOutput("t5 rx_byte held", 32'(bus.rx_byte), 32'h5A);

        // 6: async reset mid-byte, then eop coincident with a strobe
        sendBits(8'h0F, 4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkAllZero("t6 async reset");
        @(negedge clk);
        rst = 1'b0;
        sendBits(8'h07, 3);
        pulseEop(1'b1);
        checkOutput("t6 eop beats strobe", 32'(bus.align_err), 32'h1);
        sendBits(8'hC3, 7);
        checkOutput("t6 no early byte", 32'(bus.byte_ready), 32'h0);
        applyStimulus(1'b1);
        checkOutput("t6 byte_ready", 32'(bus.byte_ready), 32'h1);
        checkOutput("t6 rx_byte",    32'(bus.rx_byte),    32'hC3);

        idleCycle();
        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
